// File: rtl/spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_pkg : shared SPI master/slave types, modes and timing helpers |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // Mode encoding is {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int half_cycles(input int clk_hz, input int spi_hz);
        return clk_hz / (2 * spi_hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_master_if : request/response and serial pins of the master    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface spi_master_if #(
    parameter int data_width = 8
);
    logic                  start;
    logic [data_width-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [data_width-1:0] rx_data;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start,
        input  tx_data,
        input  miso,
        output busy,
        output done,
        output rx_data,
        output sclk,
        output cs_n,
        output mosi
    );

    modport slave (
        output start,
        output tx_data,
        output miso,
        input  busy,
        input  done,
        input  rx_data,
        input  sclk,
        input  cs_n,
        input  mosi
    );
endinterface
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_sclk_gen : half-period divider and SCLK edge counter          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int HALF  = 5,
    parameter int EDGES = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_run,
    input  wire logic i_edge_en,
    output logic      o_tick,
    output logic      o_lead_edge,
    output logic      o_trail_edge,
    output logic      o_last_edge
);
    localparam int c_DIV_W  = clog2(HALF);
    localparam int c_EDGE_W = clog2(EDGES + 1);

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic                w_tick;
    logic                w_edge;

    assign w_tick = i_run && (r_div_cnt == c_DIV_W'(HALF - 1));
    assign w_edge = w_tick && i_edge_en && (r_edge_cnt != c_EDGE_W'(EDGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (i_clear) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
        end else if (i_run) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_edge) begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end

    // Toggle number is r_edge_cnt+1: odd toggles are leading edges
    assign o_tick       = w_tick;
    assign o_lead_edge  = w_edge && !r_edge_cnt[0];
    assign o_trail_edge = w_edge && r_edge_cnt[0];
    assign o_last_edge  = w_edge && (r_edge_cnt == c_EDGE_W'(EDGES - 1));

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_master : fixed-width full-duplex MSB-first SPI master         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module spi_master
    import spi_pkg::*;
#(
    parameter int clk_frequency = 50_000_000,
    parameter int spi_frequency = 5_000_000,
    parameter int data_width    = 8,
    parameter bit CPOL          = 1'b1,
    parameter bit CPHA          = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    spi_master_if.master bus
);
    localparam int         c_HALF          = half_cycles(clk_frequency, spi_frequency);
    localparam int         c_W             = data_width;
    localparam logic [1:0] c_MODE          = {CPOL, CPHA};
    localparam bit         c_SHIFT_ON_LEAD = (c_MODE == MODE1) || (c_MODE == MODE3);

    if (c_HALF < 2) begin : g_bad_half
        $error("spi_master: clk_frequency/(2*spi_frequency) must be >= 2");
    end
    if (data_width < 2) begin : g_bad_width
        $error("spi_master: data_width must be >= 2");
    end

    spi_state_t       r_state;
    logic [c_W-1:0]   r_tx;
    logic [c_W-1:0]   r_rx;
    logic [c_W-1:0]   r_rx_data;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;

    logic w_accept;
    logic w_tick;
    logic w_lead;
    logic w_trail;
    logic w_last;
    logic w_shift;
    logic w_sample;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    spi_sclk_gen #(
        .HALF  (c_HALF),
        .EDGES (2 * c_W)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_run        (r_state != ST_IDLE),
        .i_edge_en    ((r_state == ST_SETUP) || (r_state == ST_XFER)),
        .o_tick       (w_tick),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail),
        .o_last_edge  (w_last)
    );

    // With CPHA=0 the MSB is already on mosi, so the final trailing edge has nothing to present
    assign w_shift  = c_SHIFT_ON_LEAD ? w_lead  : (w_trail && !w_last);
    assign w_sample = c_SHIFT_ON_LEAD ? w_trail : w_lead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sclk    <= CPOL;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_shift) begin
                r_mosi <= c_SHIFT_ON_LEAD ? r_tx[c_W-1] : r_tx[c_W-2];
                r_tx   <= {r_tx[c_W-2:0], 1'b0};
            end
            if (w_sample) begin
                r_rx <= {r_rx[c_W-2:0], bus.miso};
            end
            if (w_lead || w_trail) begin
                r_sclk <= ~r_sclk;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_tx    <= bus.tx_data;
                        r_busy  <= 1'b1;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= c_SHIFT_ON_LEAD ? 1'b0 : bus.tx_data[c_W-1];
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_last) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_rx_data <= r_rx;
                        r_done    <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.cs_n    = r_cs_n;
    assign bus.mosi    = r_mosi;

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Parameterised SPI master that runs one full-duplex, fixed-width, MSB-first transfer per request. It generates `sclk` and `cs_n`, shifts `tx_data` out on `mosi`, and assembles `rx_data` from `miso`. It is the initiator end of the team's SPI link: it drives the slave-side block and shares its parameter set and mode encoding.

## Interface
- `clk_frequency`, 50_000_000: system clock frequency, Hz.
- `spi_frequency`, 5_000_000: target SCLK frequency, Hz. HALF = clk_frequency/(2*spi_frequency), integer division. HALF must be ≥ 2; elaboration error otherwise.
- `data_width`, 8: bits per transfer. Must be ≥ 2.
- `CPOL`, 1: SCLK idle level.
- `CPHA`, 1: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge. Single clock domain.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request pulse/level. Accepted only when `busy`=0.
- `tx_data`  in  data_width  word to send. Latched on the accept cycle.
- `busy`  out  1  high from the accept cycle until the post-transfer gap ends.
- `done`  out  1  one-cycle pulse; `rx_data` is valid from this cycle.
- `rx_data`  out  data_width  last received word. Holds until the next `done`.
- `sclk`  out  1  SPI clock; registered output.
- `cs_n`  out  1  chip select, active-low; registered output.
- `mosi`  out  1  serial data out, MSB first; registered output.
- `miso`  in  1  serial data in. Sampled directly, no synchroniser (same clock domain as the slave's sampling).

## Operation
- State machine: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE:
  - `sclk`=CPOL, `cs_n`=1, `mosi`=0.
  - `start`=1 latches `tx_data` into the shift register, sets `busy`, and moves to SETUP.
- SETUP:
  - `cs_n`=0.
  - CPHA=0: `mosi` = MSB from the first SETUP cycle.
  - Stays HALF cycles, then XFER.
- XFER:
  - Produces 2*data_width SCLK toggles, spaced HALF cycles apart.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - Sample edge: `miso` is shifted into the rx register, LSB-side insert.
  - Shift edge: the next bit is presented on `mosi`.
  - CPHA=1: first shift on toggle 1 presents the MSB. CPHA=0: no shift on the final trailing edge.
  - After the last toggle, `sclk` = CPOL. Move to HOLD.
- HOLD:
  - `cs_n` stays 0 for HALF cycles.
  - Then `cs_n`=1, `mosi`=0, `rx_data` ← rx register, `done`=1, move to GAP.
- GAP:
  - Lasts HALF cycles with `cs_n`=1 and `busy`=1 (guaranteed deselect time).
  - Then `busy`=0 and return to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- Edge counter width = clog2(2*data_width+1). Divider counter width = clog2(HALF).
- Reset (any time, including mid-transfer) forces IDLE immediately:
  - `sclk`=CPOL, `cs_n`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
  - A partial word is discarded; no `done` is produced.

## Timing
- Accept at cycle 0. `busy`=1 and `cs_n`=0 from cycle 1.
- SCLK toggle k (k = 1..2W) at cycle 1 + k*HALF.
- `cs_n` rises and `done` pulses at cycle 1 + (2W+1)*HALF.
- `busy` falls at cycle 1 + (2W+2)*HALF. A new `start` is accepted on that cycle.
- Defaults (W=8, HALF=5): `cs_n` low at cycle 1; last toggle at 81; `done`/`cs_n` high at 86; `busy` low at 91.
- `mosi` changes at least HALF cycles before the sample edge it serves.

## Structure
- Shared package `spi_pkg`:
  - state enum.
  - `clog2` function.
  - mode localparams MODE0..MODE3 as {CPOL,CPHA}.
  - HALF computation helper, also used by the slave-side testbench.
- One natural sub-module, `spi_sclk_gen`:
  - divider plus edge counter.
  - emits `lead_edge`/`trail_edge` strobes and a `last_edge` flag.
  - the FSM and shift registers stay in `spi_master`.

## Test plan
- Mode 3 (CPOL=1, CPHA=1), `miso` looped to `mosi`, `tx_data`=0xA5 → `rx_data`=0xA5 at cycle 86; `busy` low at 91; exactly 16 SCLK toggles; `sclk` idles high.
- Mode 0, bench slave returns 0x3C while checking `mosi` on rising edges → bench sees 0xC3; `rx_data`=0x3C; first `mosi` bit stable before the first rising edge.
- `start` held high continuously with `tx_data`=0x01 then 0x80 → two transfers; `cs_n` high for exactly HALF+1 cycles between them (done cycle plus GAP); second word latched only at re-accept.
- `start` pulsed at cycles 10 and 40 during a transfer → ignored; exactly one `done`; shift contents unchanged.
- `rst_n` asserted at cycle 45 → same cycle: `cs_n`=1, `sclk`=CPOL, `busy`=0. No `done`; `rx_data`=0. A fresh transfer after release completes normally.
- data_width=16, spi_frequency=12_500_000 (HALF=2), 0xBEEF loopback → `done` at cycle 67; `rx_data`=0xBEEF.
